lsu: RTL and testbench
======================

// Module: lsu
// PURPOSE
//   Load/store unit directly downstream of the decoder. Takes one decoded memory op per
//   handshake (memOP = func3, write enable, load flag) plus the ALU-computed address and
//   rs2 data. Issues one aligned word request on the data bus and returns load data
//   sign/zero-extended for writeback. Flags misaligned, illegal, bus-error and timeout.
// PARAMETERS
//   TIMEOUT_CYC  255  max cycles in WAIT without bus_resp_valid before error; range 1..255
// PORTS
//   clk             in   1   clock
//   rst             in   1   reset, asynchronous, active-high
//   in_valid        in   1   decoded op valid
//   in_ready        out  1   LSU can accept an op (IDLE and rst low)
//   in_mem_wen      in   1   store (decoder memWriteEnable)
//   in_mem_ren      in   1   load (decoder rdInputSel==2'b01)
//   in_mem_op       in   3   func3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   in_addr         in   32  effective byte address
//   in_wdata        in   32  store data (rs2)
//   out_valid       out  1   result valid, held until out_ready
//   out_ready       in   1   writeback accepts result
//   out_rdata       out  32  extended load data; 0 for stores, non-memory ops, errors
//   out_err         out  1   misaligned / illegal op / bus error / timeout
//   bus_req_valid   out  1   bus request valid
//   bus_req_ready   in   1   bus accepts request
//   bus_req_addr    out  32  {in_addr[31:2], 2'b00}
//   bus_req_wen     out  1   1 = write
//   bus_req_wdata   out  32  lane-replicated store data
//   bus_req_wmask   out  4   byte strobes; 4'b0000 for reads
//   bus_resp_valid  in   1   response valid (one-cycle pulse)
//   bus_resp_rdata  in   32  read word
//   bus_resp_err    in   1   bus error
// BEHAVIOUR
//   FSM: IDLE, REQ, WAIT, DONE. Reset: IDLE; all outputs 0; in_ready 0 while rst high.
//   - IDLE: in_ready=1. Accept on in_valid&in_ready (cycle T); op, addr and data are latched.
//     - Neither wen nor ren (wen has priority over ren): DONE, rdata=0, err=0.
//     - Illegal op (011/110/111, or store with op[2]=1): DONE, err=1.
//     - Misaligned (H/HU: addr[0]=1; W: addr[1:0]!=0): DONE, err=1.
//     - Otherwise REQ.
//   - REQ: bus_req_* driven from latched values, stable until bus_req_ready. Then WAIT,
//     counter cleared.
//   - WAIT: response is accepted only in this state.
//     - On bus_resp_valid: extract data, err=bus_resp_err, go DONE.
//     - Else counter++; when counter==TIMEOUT_CYC: DONE, err=1, rdata=0.
//   - DONE: out_valid=1, out_rdata/out_err stable; IDLE when out_ready.
//   - No op is accepted in the DONE->IDLE transition cycle.
//   Latency: non-bus op out_valid at T+1. Bus op with ready in T+1 and resp in T+2:
//   out_valid at T+3.
//   Store lanes, o=addr[1:0]:
//     - SB: wmask=4'b0001<<o, wdata={4{wdata[7:0]}}
//     - SH: wmask=4'b0011<<o, wdata={2{wdata[15:0]}}
//     - SW: 4'b1111, wdata unchanged
//   Load: word>>(8*o); B/H sign-extend from bit 7/15; BU/HU zero-extend; W as-is.
//   Reset mid-op: immediate return to IDLE, outputs 0. A response arriving outside WAIT is
//   dropped. The bus must be reset by the same rst, so no stale response can land in a
//   new WAIT.
// STRUCTURE
//   Shared package: MEM_B/H/W/BU/HU func3 constants, LSU FSM state encoding, TIMEOUT width.
//   Sub-module lsu_align (combinational): wmask/wdata lane generation and load
//   shift/extend; lsu keeps FSM, latches and counter.
// TESTING
//   1 SB addr 0x8000_0003 wdata 0x1234_56AB, ready in REQ, resp next cycle
//     -> req_addr 0x8000_0000, wmask 4'b1000, wdata 0xABAB_ABAB, err 0, rdata 0.
//   2 LH addr 0x8000_0002, resp 0x8001_1234 -> rdata 0xFFFF_8001; LHU -> 0x0000_8001;
//     LB addr 0x...1 resp 0x0000_7F00 -> 0x0000_007F.
//   3 LW addr 0x8000_0001 -> no bus_req_valid, out_valid at T+1, err 1;
//     op 3'b011 load -> err 1.
//   4 bus_req_ready low 5 cycles, then out_ready low 3 cycles -> req fields stable,
//     out_valid/rdata stable, in_ready 0 until consumed.
//   5 TIMEOUT_CYC=4, no response -> out_valid with err 1, rdata 0 after 4 WAIT cycles;
//     resp with bus_resp_err=1 -> err 1.
//   6 rst pulse while in WAIT, resp arrives 1 cycle after release -> IDLE, outputs 0,
//     response ignored, next op completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: func3 encodings, FSM states, op checks.
// Pure declarations; no latency or backpressure of its own.
package lsu_pkg;

  localparam logic [2:0] MEM_B  = 3'b000;
  localparam logic [2:0] MEM_H  = 3'b001;
  localparam logic [2:0] MEM_W  = 3'b010;
  localparam logic [2:0] MEM_BU = 3'b100;
  localparam logic [2:0] MEM_HU = 3'b101;

  localparam int TO_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_t;

  // Unsigned widths only exist for loads; a store with op[2] set is illegal.
  function automatic logic op_legal(input logic [2:0] op, input logic wen);
    logic ok;
    case (op)
      MEM_B, MEM_H, MEM_W: ok = 1'b1;
      MEM_BU, MEM_HU:      ok = !wen;
      default:             ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic misaligned(input logic [2:0] op, input logic [1:0] off);
    logic bad;
    case (op)
      MEM_H, MEM_HU: bad = off[0];
      MEM_W:         bad = (off != 2'b00);
      default:       bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Decoder-side op handshake, writeback result handshake and data-bus request/response.
// Wires only; master is the environment, slave is the LSU.
interface lsu_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_mem_wen;
  logic        in_mem_ren;
  logic [2:0]  in_mem_op;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_rdata;
  logic        out_err;
  logic        bus_req_valid;
  logic        bus_req_ready;
  logic [31:0] bus_req_addr;
  logic        bus_req_wen;
  logic [31:0] bus_req_wdata;
  logic [3:0]  bus_req_wmask;
  logic        bus_resp_valid;
  logic [31:0] bus_resp_rdata;
  logic        bus_resp_err;

  modport slave (
    input  in_valid, in_mem_wen, in_mem_ren, in_mem_op, in_addr, in_wdata,
    input  out_ready, bus_req_ready, bus_resp_valid, bus_resp_rdata, bus_resp_err,
    output in_ready, out_valid, out_rdata, out_err,
    output bus_req_valid, bus_req_addr, bus_req_wen, bus_req_wdata, bus_req_wmask
  );

  modport master (
    output in_valid, in_mem_wen, in_mem_ren, in_mem_op, in_addr, in_wdata,
    output out_ready, bus_req_ready, bus_resp_valid, bus_resp_rdata, bus_resp_err,
    input  in_ready, out_valid, out_rdata, out_err,
    input  bus_req_valid, bus_req_addr, bus_req_wen, bus_req_wdata, bus_req_wmask
  );
endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering: store strobes/replicated data and load shift with sign/zero extension.
// Combinational, zero latency; no backpressure.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  off,
  input  logic [31:0] st_data,
  input  logic [31:0] word,
  output logic [3:0]  wmask,
  output logic [31:0] wdata,
  output logic [31:0] ldata
);

  logic [31:0] sh;

  always_comb begin
    sh    = word >> {off, 3'b000};
    wmask = 4'b1111;
    wdata = st_data;
    ldata = sh;
    case (op[1:0])
      2'b00: begin
        wmask = 4'b0001 << off;
        wdata = {4{st_data[7:0]}};
        ldata = op[2] ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      end
      2'b01: begin
        wmask = 4'b0011 << off;
        wdata = {2{st_data[15:0]}};
        ldata = op[2] ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      end
      default: begin
        wmask = 4'b1111;
        wdata = st_data;
        ldata = sh;
      end
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one op per handshake -> one aligned bus word -> extended result with error flag.
// Latency 1 cycle for non-bus ops, 3+ for bus ops; stalls on bus_req_ready, holds result until out_ready.
module lsu
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255
) (
  input logic clk,
  input logic rst,
  lsu_if.slave io
);

  localparam logic [TO_W:0] TO_LIM = (TO_W + 1)'(TIMEOUT_CYC);

  lsu_state_t      state;
  logic [2:0]      op_q;
  logic [31:0]     addr_q;
  logic [31:0]     wdata_q;
  logic            wen_q;
  logic [TO_W-1:0] cnt;
  logic [31:0]     rdata_q;
  logic            err_q;

  logic [3:0]  al_wmask;
  logic [31:0] al_wdata;
  logic [31:0] al_ldata;
  logic        req;

  lsu_align u_align (
    .op      (op_q),
    .off     (addr_q[1:0]),
    .st_data (wdata_q),
    .word    (io.bus_resp_rdata),
    .wmask   (al_wmask),
    .wdata   (al_wdata),
    .ldata   (al_ldata)
  );

  assign req              = (state == ST_REQ);
  assign io.in_ready      = (state == ST_IDLE) && !rst;
  assign io.out_valid     = (state == ST_DONE);
  assign io.out_rdata     = rdata_q;
  assign io.out_err       = err_q;
  assign io.bus_req_valid = req;
  assign io.bus_req_addr  = req ? {addr_q[31:2], 2'b00} : 32'h0;
  assign io.bus_req_wen   = req && wen_q;
  assign io.bus_req_wdata = (req && wen_q) ? al_wdata : 32'h0;
  assign io.bus_req_wmask = (req && wen_q) ? al_wmask : 4'b0000;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      op_q    <= 3'b000;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      wen_q   <= 1'b0;
      cnt     <= '0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (io.in_valid) begin
            op_q    <= io.in_mem_op;
            addr_q  <= io.in_addr;
            wdata_q <= io.in_wdata;
            wen_q   <= io.in_mem_wen;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
            if (!io.in_mem_wen && !io.in_mem_ren) begin
              state <= ST_DONE;
            end else if (!op_legal(io.in_mem_op, io.in_mem_wen) ||
                         misaligned(io.in_mem_op, io.in_addr[1:0])) begin
              err_q <= 1'b1;
              state <= ST_DONE;
            end else begin
              state <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (io.bus_req_ready) begin
            cnt   <= '0;
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (io.bus_resp_valid) begin
            err_q   <= io.bus_resp_err;
            rdata_q <= (io.bus_resp_err || wen_q) ? 32'h0 : al_ldata;
            state   <= ST_DONE;
          end else if ({1'b0, cnt} + 1'b1 == TO_LIM) begin
            err_q   <= 1'b1;
            rdata_q <= 32'h0;
            state   <= ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: begin
          if (io.out_ready) begin
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu with a result scoreboard and an inline bus responder.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_lsu;
  import lsu_pkg::*;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  res_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  lsu_if io ();

  lsu #(.TIMEOUT_CYC(4)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(
    input string       tag,
    input logic        wen,
    input logic        ren,
    input logic [2:0]  op,
    input logic [31:0] addr,
    input logic [31:0] wd,
    input logic        bus,
    input logic [3:0]  exp_wmask,
    input logic [31:0] exp_wdata,
    input int          req_dly,
    input logic        resp,
    input logic [31:0] resp_rd,
    input logic        resp_err,
    input int          out_dly,
    input logic [31:0] exp_rd,
    input logic        exp_err
  );
    int   n;
    res_t e;
    io.in_valid   = 1'b1;
    io.in_mem_wen = wen;
    io.in_mem_ren = ren;
    io.in_mem_op  = op;
    io.in_addr    = addr;
    io.in_wdata   = wd;
    n = 0;
    while (!io.in_ready && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_in_ready"}, 32'(io.in_ready), 32'd1);
    tick();
    io.in_valid = 1'b0;
    sb_q.push_back(res_t'{exp_rd, exp_err});
    if (bus) begin
      check({tag, "_req_vld"}, 32'(io.bus_req_valid), 32'd1);
      check({tag, "_req_addr"}, io.bus_req_addr, {addr[31:2], 2'b00});
      check({tag, "_req_wen"}, 32'(io.bus_req_wen), 32'(wen));
      check({tag, "_req_wmask"}, 32'(io.bus_req_wmask), 32'(exp_wmask));
      if (wen) check({tag, "_req_wdata"}, io.bus_req_wdata, exp_wdata);
      for (int i = 0; i < req_dly; i++) begin
        io.bus_req_ready = 1'b0;
        tick();
        check({tag, "_hold_vld"}, 32'(io.bus_req_valid), 32'd1);
        check({tag, "_hold_addr"}, io.bus_req_addr, {addr[31:2], 2'b00});
        check({tag, "_hold_wmask"}, 32'(io.bus_req_wmask), 32'(exp_wmask));
        check({tag, "_hold_in_rdy"}, 32'(io.in_ready), 32'd0);
      end
      io.bus_req_ready = 1'b1;
      tick();
      io.bus_req_ready = 1'b0;
      check({tag, "_req_drop"}, 32'(io.bus_req_valid), 32'd0);
      check({tag, "_early_ovld"}, 32'(io.out_valid), 32'd0);
      if (resp) begin
        io.bus_resp_valid = 1'b1;
        io.bus_resp_rdata = resp_rd;
        io.bus_resp_err   = resp_err;
        tick();
        io.bus_resp_valid = 1'b0;
        io.bus_resp_rdata = 32'h0;
        io.bus_resp_err   = 1'b0;
      end else begin
        n = 0;
        while (!io.out_valid && n < 20) begin
          tick();
          n++;
        end
        check({tag, "_timeout_cyc"}, 32'(n), 32'd4);
      end
    end else begin
      check({tag, "_no_req"}, 32'(io.bus_req_valid), 32'd0);
    end
    check({tag, "_ovld"}, 32'(io.out_valid), 32'd1);
    for (int i = 0; i < out_dly; i++) begin
      tick();
      check({tag, "_stall_ovld"}, 32'(io.out_valid), 32'd1);
      check({tag, "_stall_rdata"}, io.out_rdata, sb_q[0].rdata);
      check({tag, "_stall_in_rdy"}, 32'(io.in_ready), 32'd0);
    end
    e = sb_q.pop_front();
    check({tag, "_rdata"}, io.out_rdata, e.rdata);
    check({tag, "_err"}, 32'(io.out_err), 32'(e.err));
    io.out_ready = 1'b1;
    tick();
    io.out_ready = 1'b0;
    check({tag, "_consumed"}, 32'(io.out_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst               = 1'b1;
    io.in_valid       = 1'b0;
    io.in_mem_wen     = 1'b0;
    io.in_mem_ren     = 1'b0;
    io.in_mem_op      = 3'b000;
    io.in_addr        = 32'h0;
    io.in_wdata       = 32'h0;
    io.out_ready      = 1'b0;
    io.bus_req_ready  = 1'b0;
    io.bus_resp_valid = 1'b0;
    io.bus_resp_rdata = 32'h0;
    io.bus_resp_err   = 1'b0;
    tick();
    tick();
    check("rst_in_ready", 32'(io.in_ready), 32'd0);
    check("rst_out_valid", 32'(io.out_valid), 32'd0);
    check("rst_req_valid", 32'(io.bus_req_valid), 32'd0);
    check("rst_out_rdata", io.out_rdata, 32'h0);
    check("rst_out_err", 32'(io.out_err), 32'd0);
    rst = 1'b0;
    tick();

    // Stores: lane strobes and replication
    run_op("sb", 1, 0, MEM_B, 32'h8000_0003, 32'h1234_56AB, 1, 4'b1000, 32'hABAB_ABAB,
           0, 1, 32'h0, 0, 0, 32'h0, 0);
    run_op("sh", 1, 0, MEM_H, 32'h8000_0006, 32'h1234_ABCD, 1, 4'b1100, 32'hABCD_ABCD,
           0, 1, 32'h0, 0, 0, 32'h0, 0);
    run_op("sw", 1, 0, MEM_W, 32'h8000_0008, 32'hDEAD_BEEF, 1, 4'b1111, 32'hDEAD_BEEF,
           0, 1, 32'h0, 0, 0, 32'h0, 0);

    // Loads: shift and extension
    run_op("lh", 0, 1, MEM_H, 32'h8000_0002, 32'h0, 1, 4'b0000, 32'h0,
           0, 1, 32'h8001_1234, 0, 0, 32'hFFFF_8001, 0);
    run_op("lhu", 0, 1, MEM_HU, 32'h8000_0002, 32'h0, 1, 4'b0000, 32'h0,
           0, 1, 32'h8001_1234, 0, 0, 32'h0000_8001, 0);
    run_op("lb", 0, 1, MEM_B, 32'h8000_0001, 32'h0, 1, 4'b0000, 32'h0,
           0, 1, 32'h0000_7F00, 0, 0, 32'h0000_007F, 0);
    run_op("lbu", 0, 1, MEM_BU, 32'h8000_0003, 32'h0, 1, 4'b0000, 32'h0,
           0, 1, 32'h80FF_FFFF, 0, 0, 32'h0000_0080, 0);
    run_op("lb_neg", 0, 1, MEM_B, 32'h8000_0003, 32'h0, 1, 4'b0000, 32'h0,
           0, 1, 32'h80FF_FFFF, 0, 0, 32'hFFFF_FF80, 0);
    run_op("lw", 0, 1, MEM_W, 32'h8000_000C, 32'h0, 1, 4'b0000, 32'h0,
           0, 1, 32'h1357_9BDF, 0, 0, 32'h1357_9BDF, 0);

    // Ops that complete without touching the bus
    run_op("lw_misal", 0, 1, MEM_W, 32'h8000_0001, 32'h0, 0, 4'b0000, 32'h0,
           0, 0, 32'h0, 0, 0, 32'h0, 1);
    run_op("ld_ill", 0, 1, 3'b011, 32'h8000_0000, 32'h0, 0, 4'b0000, 32'h0,
           0, 0, 32'h0, 0, 0, 32'h0, 1);
    run_op("st_ill", 1, 0, MEM_BU, 32'h8000_0000, 32'h55, 0, 4'b0000, 32'h0,
           0, 0, 32'h0, 0, 0, 32'h0, 1);
    run_op("sh_misal", 1, 0, MEM_H, 32'h8000_0001, 32'h55, 0, 4'b0000, 32'h0,
           0, 0, 32'h0, 0, 0, 32'h0, 1);
    run_op("no_mem", 0, 0, 3'b011, 32'h8000_0001, 32'h55, 0, 4'b0000, 32'h0,
           0, 0, 32'h0, 0, 0, 32'h0, 0);

    // Request and result backpressure
    run_op("stall", 0, 1, MEM_W, 32'h8000_0010, 32'h0, 1, 4'b0000, 32'h0,
           5, 1, 32'hCAFE_F00D, 0, 3, 32'hCAFE_F00D, 0);

    // Timeout and bus error
    run_op("timeout", 0, 1, MEM_W, 32'h8000_0014, 32'h0, 1, 4'b0000, 32'h0,
           0, 0, 32'h0, 0, 0, 32'h0, 1);
    run_op("bus_err", 0, 1, MEM_W, 32'h8000_0018, 32'h0, 1, 4'b0000, 32'h0,
           0, 1, 32'h1234_5678, 1, 0, 32'h0, 1);

    // Reset while waiting for a response; the late response must be dropped
    io.in_valid   = 1'b1;
    io.in_mem_wen = 1'b0;
    io.in_mem_ren = 1'b1;
    io.in_mem_op  = MEM_W;
    io.in_addr    = 32'h8000_0020;
    check("rst6_in_ready", 32'(io.in_ready), 32'd1);
    tick();
    io.in_valid = 1'b0;
    check("rst6_req_vld", 32'(io.bus_req_valid), 32'd1);
    io.bus_req_ready = 1'b1;
    tick();
    io.bus_req_ready = 1'b0;
    rst = 1'b1;
    #1;
    check("rst6_hold_in_rdy", 32'(io.in_ready), 32'd0);
    check("rst6_hold_ovld", 32'(io.out_valid), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    io.bus_resp_valid = 1'b1;
    io.bus_resp_rdata = 32'h5555_5555;
    tick();
    io.bus_resp_valid = 1'b0;
    io.bus_resp_rdata = 32'h0;
    check("rst6_ovld", 32'(io.out_valid), 32'd0);
    check("rst6_req", 32'(io.bus_req_valid), 32'd0);
    check("rst6_idle", 32'(io.in_ready), 32'd1);
    check("rst6_rdata", io.out_rdata, 32'h0);
    check("rst6_err", 32'(io.out_err), 32'd0);
    run_op("post_rst", 0, 1, MEM_HU, 32'h8000_0022, 32'h0, 1, 4'b0000, 32'h0,
           0, 1, 32'hBEEF_0000, 0, 0, 32'h0000_BEEF, 0);

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
